ram_write_stream_mux: RTL

- Parametrised successor to the RAM-input selector of the IO module.
- Selects one of N_SRC byte-stream producers (e.g. decompressor, file loader, CNN output, layer input) and streams a burst of words into the shared RAM.
- Handles source handshake, write-address generation, burst length and completion signalling.
- Sits between the data producers and the RAM write port; replaces a purely combinational select with a registered, flow-controlled write engine.

---
 rtl/ram_write_stream_mux.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ram_write_stream_mux.sv
// Registered, flow-controlled burst writer: streams one of N_SRC source channels
// into a RAM write port with generated addresses, length control and status pulses.
module ram_write_stream_mux #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int N_SRC  = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [SEL_W-1:0]        mode,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       length,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    output logic                    ram_we,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       ram_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [SEL_W:0] N_SRC_L = (SEL_W+1)'(N_SRC);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    mode_q, mode_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   sel_data_s;
    logic                sel_valid_s;
    logic                accept_s;
    logic [N_SRC-1:0]    ready_s;

    // Route the latched channel's valid/data and raise only its ready while running.
    always_comb begin
        sel_data_s  = '0;
        sel_valid_s = 1'b0;
        ready_s     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (mode_q == SEL_W'(i)) begin
                sel_data_s  = src_data[i*DATA_W +: DATA_W];
                sel_valid_s = src_valid[i];
                ready_s[i]  = (state_q == S_RUN);
            end else begin
                ready_s[i]  = 1'b0;
            end
        end
        accept_s = sel_valid_s && (state_q == S_RUN);
    end

    // Next-state, burst bookkeeping and next values of the registered RAM port.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        base_d     = base_q;
        len_d      = len_q;
        count_d    = count_q;
        err_d      = 1'b0;
        ram_we_d   = accept_s;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        if (accept_s) begin
            ram_addr_d = base_q + count_q;
            ram_data_d = sel_data_s;
        end else begin
            ram_addr_d = ram_addr_q;
            ram_data_d = ram_data_q;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ({1'b0, mode} >= N_SRC_L) begin
                        err_d = 1'b1;
                    end else if (length == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        mode_d  = mode;
                        base_d  = base_addr;
                        len_d   = length;
                        count_d = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept_s) begin
                    count_d = count_q + ADDR_W'(1);
                end else begin
                    count_d = count_q;
                end
                // Abort wins over completion; an accepted word is still written.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (accept_s && (count_q == len_q - ADDR_W'(1))) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            base_q     <= '0;
            len_q      <= '0;
            count_q    <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            base_q     <= base_d;
            len_q      <= len_d;
            count_q    <= count_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            err_q      <= err_d;
        end
    end

    assign src_ready = ready_s;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;

endmodule
